// File: rtl/pico_stream_pkg.sv
// Shared definitions for the pico firmware streams: word width, word type and
// a constant-evaluable log2 helper used to size pointers.
package pico_stream_pkg;

  localparam int STREAM_NUM_BITS = 64;

  typedef logic [STREAM_NUM_BITS-1:0] stream_word_t;

  // Smallest n with 2**n >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_out_fifo_ram.sv
// Storage array for stream_out_fifo: one synchronous write port and one
// asynchronous read port, so the head word is visible in the same cycle.
module stream_out_fifo_ram #(
  parameter int NUM_BITS = 64,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [NUM_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [NUM_BITS-1:0] rdata
);

  logic [NUM_BITS-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; validity is tracked by the
  // occupancy counter, and a reset here would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_out_fifo.sv
// Elastic buffer between firmware stream #1 output and the host-bound stream.
// Define STREAM_OUT_FIFO_HWM_EN to add the occupancy high-water-mark port.
module stream_out_fifo
  import pico_stream_pkg::*;
#(
  parameter int  NUM_BITS = STREAM_NUM_BITS,
  parameter int  DEPTH    = 16,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s1o_valid,
  output logic                s1o_rdy,
  input  logic [NUM_BITS-1:0] s1o_data,
  output logic                h1_valid,
  input  logic                h1_rdy,
  output logic [NUM_BITS-1:0] h1_data,
  output logic [ADDR_W:0]     level
`ifdef STREAM_OUT_FIFO_HWM_EN
  ,
  input  logic                hwm_clr,
  output logic [ADDR_W:0]     hwm
`endif
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     level_next;
  logic [NUM_BITS-1:0] head_word;
  logic                write;
  logic                read;

  // Ready depends only on registered occupancy, so a read in a full cycle
  // does not open a slot until the following cycle.
  assign s1o_rdy  = (level != FULL_LEVEL) & ~rst;
  assign h1_valid = (level != '0);
  assign h1_data  = h1_valid ? head_word : '0;

  assign write = s1o_valid & s1o_rdy;
  assign read  = h1_valid & h1_rdy;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    level_next = level;
    case ({write, read})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
    end
  end

  stream_out_fifo_ram #(
    .NUM_BITS (NUM_BITS),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (write),
    .waddr (wr_ptr),
    .wdata (s1o_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

`ifdef STREAM_OUT_FIFO_HWM_EN
  // A clear loads the post-edge level rather than zero, so an occupied
  // FIFO keeps reporting its true level after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm <= '0;
    end else if (hwm_clr) begin
      hwm <= level_next;
    end else if (level_next > hwm) begin
      hwm <= level_next;
    end
  end
`endif

endmodule

// File: tb/tb_stream_out_fifo.sv
// Self-checking bench for stream_out_fifo (DEPTH=4): directed boundary cases
// plus randomized stalls, compared against a queue-based reference model.
module tb_stream_out_fifo;

  localparam int NUM_BITS = 64;
  localparam int DEPTH    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s1o_valid;
  logic          s1o_rdy;
  logic [63:0]   s1o_data;
  logic          h1_valid;
  logic          h1_rdy;
  logic [63:0]   h1_data;
  logic [2:0]    level;
`ifdef STREAM_OUT_FIFO_HWM_EN
  logic          hwm_clr;
  logic [2:0]    hwm;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;
  int n_out    = 0;

  // Reference model: the words the FIFO should currently hold, head first.
  logic [63:0] model [$];

  always #5 clk = ~clk;

  stream_out_fifo #(
    .NUM_BITS (NUM_BITS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s1o_valid (s1o_valid),
    .s1o_rdy   (s1o_rdy),
    .s1o_data  (s1o_data),
    .h1_valid  (h1_valid),
    .h1_rdy    (h1_rdy),
    .h1_data   (h1_data),
    .level     (level)
`ifdef STREAM_OUT_FIFO_HWM_EN
    ,
    .hwm_clr   (hwm_clr),
    .hwm       (hwm)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then let
  // the edge happen and apply the handshake rules to the model.
  task automatic cycle(input logic v, input logic [63:0] d, input logic r);
    logic exp_w;
    logic exp_r;
    s1o_valid = v;
    s1o_data  = d;
    h1_rdy    = r;
    #1;
    check("s1o_rdy",  s1o_rdy,  model.size() < DEPTH);
    check("h1_valid", h1_valid, model.size() != 0);
    check("h1_data",  h1_data,  (model.size() != 0) ? model[0] : 64'd0);
    check("level",    level,    model.size());
    exp_w = v && (model.size() < DEPTH);
    exp_r = r && (model.size() != 0);
    @(posedge clk);
    if (exp_r) begin
      void'(model.pop_front());
      n_out++;
    end
    if (exp_w) begin
      model.push_back(d);
      n_in++;
    end
    #1;
  endtask

  // Assert reset away from any clock edge and check it takes effect at once.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_level",    level,    0);
    check("rst_h1_valid", h1_valid, 0);
    check("rst_h1_data",  h1_data,  0);
    check("rst_s1o_rdy",  s1o_rdy,  0);
    model.delete();
    s1o_valid = 1'b0;
    h1_rdy    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s1o_rdy", s1o_rdy, 1);
    check("post_rst_level",   level,   0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    s1o_valid = 1'b0;
    s1o_data  = '0;
    h1_rdy    = 1'b0;
`ifdef STREAM_OUT_FIFO_HWM_EN
    hwm_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("in_rst_s1o_rdy", s1o_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_level",    level,    0);
    check("idle_h1_valid", h1_valid, 0);
    check("idle_h1_data",  h1_data,  0);
    check("idle_s1o_rdy",  s1o_rdy,  1);
    cycle(1'b0, 64'd0, 1'b1);

    // Fill with the consumer stalled, then offer a fifth word.
    for (int i = 5; i <= 8; i++) cycle(1'b1, 64'(i), 1'b0);
    check("full_level",   level,   4);
    check("full_s1o_rdy", s1o_rdy, 0);
    cycle(1'b1, 64'd9, 1'b0);
    check("held_level", level, 4);

    // Read once from full: ready stays low that cycle, rises after.
    cycle(1'b1, 64'd9, 1'b1);
    check("after_read_level",   level,   3);
    check("after_read_s1o_rdy", s1o_rdy, 1);
    cycle(1'b1, 64'd9, 1'b0);
    check("refill_level", level, 4);
    repeat (4) cycle(1'b0, 64'd0, 1'b1);
    check("drained_level", level, 0);

    // Continuous streaming: level settles at 1, pointers wrap many times.
    for (int k = 5; k <= 104; k++) begin
      cycle(1'b1, 64'(k), 1'b1);
      if (k > 5) check("stream_level", level, 1);
    end
    cycle(1'b0, 64'd0, 1'b1);
    check("stream_drained", level, 0);

    // Random stalls on both sides.
    n_in  = 0;
    n_out = 0;
    for (int c = 0; c < 20000 && n_out < 1000; c++) begin
      cycle((n_in < 1000) && ($urandom_range(0, 1) == 1),
            {$urandom, $urandom},
            $urandom_range(0, 1) == 1);
    end
    check("random_words_out", n_out, 1000);
    check("random_words_in",  n_in,  1000);

    // Reset in the middle of a burst at level 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'(200 + i), 1'b0);
    check("pre_rst_level", level, 3);
    async_reset();
    cycle(1'b1, 64'd300, 1'b0);
    cycle(1'b0, 64'd0, 1'b1);

`ifdef STREAM_OUT_FIFO_HWM_EN
    async_reset();
    check("hwm_reset", hwm, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'(400 + i), 1'b0);
    check("hwm_fill3", hwm, 3);
    repeat (3) cycle(1'b0, 64'd0, 1'b1);
    check("hwm_level0", level, 0);
    check("hwm_after_drain", hwm, 3);
    hwm_clr = 1'b1;
    cycle(1'b0, 64'd0, 1'b0);
    hwm_clr = 1'b0;
    check("hwm_cleared", hwm, 0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 64'(500 + i), 1'b0);
    check("hwm_refill2", hwm, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
